massbus_drive_responder: RTL and testbench

//   Drive-side (slave) end of the KS10 Massbus link: the generic responder the
//   RH11 master talks to. It answers register reads/writes, decodes GO

---
 rtl/massbus_drive_responder.sv | 184 ++++++++++++++++++
 tb/tb_massbus_drive_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/massbus_drive_responder.sv
// Drive-side Massbus responder: register file, GO decode and sector-buffer
// word transfers using the REQO/ACKI handshake with the RH11 master.
module massbus_drive_responder #(
  parameter logic [2:0]  UNIT      = 3'd0,
  parameter int          SECTWORDS = 128,
  parameter int          ACKDLY    = 2,
  parameter logic [15:0] DTYPE     = 16'o20022
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mbINIT,
  input  logic        mbREAD,
  input  logic        mbWRITE,
  input  logic [4:0]  mbREGSEL,
  input  logic [2:0]  mbUNIT,
  input  logic [4:0]  mbFUN,
  input  logic        mbGO,
  input  logic [35:0] mbDATAI,
  input  logic        mbWCZ,
  input  logic        mbACKI,
  output logic [35:0] mbDATAO,
  output logic        mbREQO,
  output logic        mbINCBA,
  output logic        mbINCWC,
  output logic        mbNPRO,
  output logic [15:0] mbREGDAT,
  output logic        mbREGACK,
  output logic        mbATA,
  output logic        mbDVA,
  output logic        mbDPR,
  output logic        mbDRY,
  output logic [7:0]  bufADDR,
  output logic [35:0] bufWDAT,
  output logic        bufWE,
  input  logic [35:0] bufRDAT
);

  typedef enum logic [2:0] {IDLE, RDFETCH, RDREQ, WRREQ, DONE} state_t;
  localparam logic [7:0] LASTIDX = 8'(SECTWORDS - 1);

  state_t      state, nextState;
  logic [4:0]  fun, funNext;
  logic [2:0]  er, erNext;
  logic        ata, ataNext;
  logic [15:0] da, daNext;
  logic [7:0]  idx;
  logic        reqo, fetched;
  logic        ackPend;
  logic [3:0]  ackCnt;
  logic        regWr;
  logic [4:0]  regSel;
  logic [15:0] regWdat, regRdat;
  logic        regBad, busy, unitHit, regStrobe, regFire, wrBusy;
  logic        goHit, startRd, startWr, ackXfer;

  assign busy      = (state == RDFETCH) || (state == RDREQ) || (state == WRREQ);
  assign mbDRY     = !busy;
  assign mbNPRO    = busy;
  assign mbDVA     = 1'b1;
  assign mbDPR     = 1'b1;
  assign mbATA     = ata;
  assign mbREQO    = reqo;
  assign unitHit   = (mbUNIT == UNIT);
  assign regStrobe = !ackPend && (mbREAD || mbWRITE) && unitHit;
  assign regFire   = ackPend && (ackCnt == 4'd1);
  assign wrBusy    = regFire && regWr && ((regSel == 5'd0) || (regSel == 5'd4)) && busy;
  assign goHit     = mbGO && unitHit;
  assign startRd   = goHit && !busy && (mbFUN == 5'o34);
  assign startWr   = goHit && !busy && (mbFUN == 5'o30);
  assign ackXfer   = reqo && mbACKI && ((state == RDREQ) || (state == WRREQ));
  assign bufADDR   = idx;
  assign bufWDAT   = mbDATAI;
  assign bufWE     = ackXfer && (state == WRREQ) && !mbINIT;

  always_comb begin
    regBad = 1'b0;
    case (regSel)
      5'd0:    regRdat = {8'b0, mbDRY, 1'b0, fun, 1'b0};
      5'd1:    regRdat = {ata, |er, 1'b0, 1'b1, 3'b0, 1'b1, mbDRY, 7'b0};
      5'd2:    regRdat = {13'b0, er};
      5'd3:    regRdat = {15'b0, ata} << UNIT;
      5'd4:    regRdat = da;
      5'd6:    regRdat = DTYPE;
      default: begin regRdat = 16'h0; regBad = 1'b1; end
    endcase
  end

  // Status register updates; later statements take priority within a clock.
  always_comb begin
    erNext  = er;
    ataNext = ata;
    daNext  = da;
    funNext = fun;
    if (regFire && regWr) begin
      case (regSel)
        5'd0:    if (!busy) funNext = regWdat[5:1];
        5'd2:    erNext = regWdat[2:0];
        5'd3:    if (regWdat[UNIT]) ataNext = 1'b0;
        5'd4:    if (!busy) daNext = regWdat;
        default: ;
      endcase
    end
    if (regFire && regBad) erNext[1] = 1'b1;
    if (wrBusy) erNext[2] = 1'b1;
    if (ackXfer && (idx == LASTIDX)) daNext[7:0] = da[7:0] + 8'd1;
    if (state == DONE) ataNext = 1'b1;
    if (goHit) begin
      if (busy) erNext[2] = 1'b1;
      else begin
        funNext = mbFUN;
        case (mbFUN)
          5'o00, 5'o30, 5'o34: ;
          5'o04:   begin erNext = 3'b0; ataNext = 1'b0; end
          default: begin erNext[0] = 1'b1; ataNext = 1'b1; end
        endcase
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (startRd)            nextState = RDFETCH;
        else if (startWr)       nextState = WRREQ;
        else if (state == DONE) nextState = IDLE;
      end
      RDFETCH: begin
        if (!fetched && mbWCZ) nextState = DONE;
        else if (fetched)      nextState = RDREQ;
      end
      RDREQ:   if (ackXfer) nextState = mbWCZ ? DONE : RDFETCH;
      WRREQ:   if ((!reqo || ackXfer) && mbWCZ) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      {fun, er, ata, da, idx, reqo, fetched, mbINCBA, mbINCWC} <= '0;
      {ackPend, ackCnt, mbREGACK, mbREGDAT, mbDATAO} <= '0;
    end else if (mbINIT) begin
      state <= IDLE;
      {fun, er, ata, da, idx, reqo, fetched, mbINCBA, mbINCWC} <= '0;
      {ackPend, ackCnt, mbREGACK, mbREGDAT, mbDATAO} <= '0;
    end else begin
      state   <= nextState;
      fun     <= funNext;
      er      <= erNext;
      ata     <= ataNext;
      da      <= daNext;
      mbINCBA <= ackXfer;
      mbINCWC <= ackXfer;
      // RDFETCH spends one clock presenting the address, then latches the RAM word.
      fetched <= (state == RDFETCH) && !fetched && !mbWCZ;
      if (ackXfer) reqo <= 1'b0;
      else if ((state == RDFETCH) && fetched) reqo <= 1'b1;
      else if ((state == WRREQ) && !reqo && !mbWCZ) reqo <= 1'b1;
      if ((state == RDFETCH) && fetched) mbDATAO <= bufRDAT;
      if (startRd || startWr) idx <= 8'd0;
      else if (ackXfer) idx <= (idx == LASTIDX) ? 8'd0 : idx + 8'd1;
      mbREGACK <= regFire;
      if (regFire) begin
        mbREGDAT <= regRdat;
        ackPend  <= 1'b0;
      end else if (ackPend) begin
        ackCnt <= ackCnt - 4'd1;
      end else if (regStrobe) begin
        ackPend <= 1'b1;
        ackCnt  <= 4'(ACKDLY);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (regStrobe) begin
      regWr   <= mbWRITE;
      regSel  <= mbREGSEL;
      regWdat <= mbDATAI[15:0];
    end
  end

endmodule

// File: tb/tb_massbus_drive_responder.sv
// Directed bench for massbus_drive_responder: register access, READ/WRITE
// transfers against a behavioural sector RAM, error paths and bus init.
module tb_massbus_drive_responder;

  localparam int TMO    = 12;
  localparam int ACKDLY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mbINIT = 1'b0, mbREAD = 1'b0, mbWRITE = 1'b0, mbGO = 1'b0;
  logic        mbWCZ = 1'b0, mbACKI = 1'b0;
  logic [4:0]  mbREGSEL = '0, mbFUN = '0;
  logic [2:0]  mbUNIT = '0;
  logic [35:0] mbDATAI = '0;
  logic [35:0] mbDATAO, bufWDAT, bufRDAT;
  logic        mbREQO, mbINCBA, mbINCWC, mbNPRO, mbREGACK, mbATA, mbDVA, mbDPR, mbDRY, bufWE;
  logic [15:0] mbREGDAT;
  logic [7:0]  bufADDR;

  logic [35:0] mem [0:255];
  logic        loadMem = 1'b1;
  int          incbaCnt = 0, incwcCnt = 0;
  int          passCnt = 0, failCnt = 0, totCnt = 0;

  massbus_drive_responder #(.UNIT(3'd0), .SECTWORDS(128), .ACKDLY(ACKDLY), .DTYPE(16'o20022)) dut (
    .clk(clk), .rst(rst), .mbINIT(mbINIT), .mbREAD(mbREAD), .mbWRITE(mbWRITE),
    .mbREGSEL(mbREGSEL), .mbUNIT(mbUNIT), .mbFUN(mbFUN), .mbGO(mbGO), .mbDATAI(mbDATAI),
    .mbWCZ(mbWCZ), .mbACKI(mbACKI), .mbDATAO(mbDATAO), .mbREQO(mbREQO), .mbINCBA(mbINCBA),
    .mbINCWC(mbINCWC), .mbNPRO(mbNPRO), .mbREGDAT(mbREGDAT), .mbREGACK(mbREGACK),
    .mbATA(mbATA), .mbDVA(mbDVA), .mbDPR(mbDPR), .mbDRY(mbDRY), .bufADDR(bufADDR),
    .bufWDAT(bufWDAT), .bufWE(bufWE), .bufRDAT(bufRDAT)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] pat(input int i);
    return 36'h9_0000_0000 | 36'(i * 3 + 1);
  endfunction

  always @(posedge clk) begin
    if (loadMem) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      if (bufWE) mem[bufADDR] <= bufWDAT;
      bufRDAT <= mem[bufADDR];
    end
  end

  always @(negedge clk) begin
    if (mbINCBA) incbaCnt++;
    if (mbINCWC) incwcCnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic regOp(input bit wr, input logic [4:0] sel, input logic [15:0] d,
                       input logic [2:0] unit, output logic [15:0] rd, output int lat);
    mbREGSEL = sel; mbUNIT = unit; mbDATAI = {20'b0, d};
    mbWRITE = wr; mbREAD = !wr;
    @(negedge clk);
    mbWRITE = 1'b0; mbREAD = 1'b0; mbUNIT = 3'd0;
    rd = 'x; lat = 0;
    while (lat < TMO) begin
      if (mbREGACK) begin rd = mbREGDAT; break; end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rdReg(input logic [4:0] sel, output logic [15:0] v);
    int l;
    regOp(1'b0, sel, 16'h0, 3'd0, v, l);
    if (l >= TMO) check("regack timeout", 64'(l), 64'(ACKDLY));
  endtask

  task automatic wrReg(input logic [4:0] sel, input logic [15:0] d);
    int l;
    logic [15:0] v;
    regOp(1'b1, sel, d, 3'd0, v, l);
    if (l >= TMO) check("regack timeout", 64'(l), 64'(ACKDLY));
  endtask

  task automatic goFun(input logic [4:0] f);
    mbFUN = f; mbUNIT = 3'd0; mbGO = 1'b1;
    @(negedge clk);
    mbGO = 1'b0;
  endtask

  task automatic xfer(input bit wcz, input logic [35:0] wd, output logic [35:0] got);
    int n = 0;
    while (!mbREQO && n < 40) begin @(negedge clk); n++; end
    got = 'x;
    if (!mbREQO) check("reqo timeout", 64'(n), 64'(0));
    else begin
      got = mbDATAO;
      mbACKI = 1'b1; mbWCZ = wcz; mbDATAI = wd;
      @(negedge clk);
      mbACKI = 1'b0; mbWCZ = 1'b0;
    end
  endtask

  task automatic waitDry();
    int n = 0;
    while (!mbDRY && n < 40) begin @(negedge clk); n++; end
    if (!mbDRY) check("dry timeout", 64'(n), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [35:0] g;
    int lat, b, bw;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; loadMem = 1'b0;
    @(negedge clk);
    check("reset outputs", 64'({mbDRY, mbDVA, mbDPR, mbREQO, mbNPRO, mbATA, mbREGACK, mbINCBA, bufWE}),
          64'(9'b111000000));

    regOp(1'b0, 5'd6, 16'h0, 3'd0, v, lat);
    check("DT ack latency", 64'(lat), 64'(2));
    check("DT value", 64'(v), 64'(16'o20022));
    rdReg(5'd1, v);       check("DS idle", 64'(v), 64'(16'o010600));
    wrReg(5'd4, 16'o5);
    rdReg(5'd4, v);       check("DA write", 64'(v), 64'(16'o5));
    regOp(1'b0, 5'd6, 16'h0, 3'd5, v, lat);
    check("other unit no ack", 64'(lat), 64'(TMO));

    // READ of three words
    b = incbaCnt; bw = incwcCnt;
    goFun(5'o34);
    check("read busy flags", 64'({mbNPRO, mbDRY}), 64'(2'b10));
    xfer(1'b0, 36'h0, g); check("read word0", 64'(g), 64'(pat(0)));
    check("reqo dropped", 64'(mbREQO), 64'(0));
    xfer(1'b0, 36'h0, g); check("read word1", 64'(g), 64'(pat(1)));
    xfer(1'b1, 36'h0, g); check("read word2", 64'(g), 64'(pat(2)));
    waitDry();
    check("read incba", 64'(incbaCnt - b), 64'(3));
    check("read incwc", 64'(incwcCnt - bw), 64'(3));
    check("read ata", 64'(mbATA), 64'(1));
    rdReg(5'd4, v);       check("read DA kept", 64'(v), 64'(16'o5));
    rdReg(5'd2, v);       check("read ER clear", 64'(v), 64'(0));

    // WRITE of 130 words, wrapping the 128-word sector
    b = incbaCnt;
    goFun(5'o30);
    for (int i = 0; i < 130; i++) xfer(i == 129, 36'(i), g);
    waitDry();
    check("write buf0", 64'(mem[0]), 64'(128));
    check("write buf1", 64'(mem[1]), 64'(129));
    check("write buf2", 64'(mem[2]), 64'(2));
    check("write buf127", 64'(mem[127]), 64'(127));
    rdReg(5'd4, v);       check("write DA wrap", 64'(v), 64'(16'o6));
    check("write incba", 64'(incbaCnt - b), 64'(130));

    // GO and DA write while busy
    goFun(5'o34);
    xfer(1'b0, 36'h0, g); check("busy word0", 64'(g), 64'(128));
    goFun(5'o34);
    rdReg(5'd2, v);       check("busy GO RMR", 64'(v), 64'(4));
    wrReg(5'd4, 16'o777);
    rdReg(5'd4, v);       check("busy DA kept", 64'(v), 64'(16'o6));
    rdReg(5'd1, v);       check("busy DS", 64'(v), 64'(16'o150400));
    xfer(1'b0, 36'h0, g); check("busy word1", 64'(g), 64'(129));
    xfer(1'b1, 36'h0, g); check("busy word2", 64'(g), 64'(2));
    waitDry();

    // Error and attention paths
    wrReg(5'd2, 16'h0);
    rdReg(5'd2, v);       check("ER write", 64'(v), 64'(0));
    wrReg(5'd3, 16'h1);   check("AS clear ata", 64'(mbATA), 64'(0));
    goFun(5'o17);
    rdReg(5'd2, v);       check("illegal fun ILF", 64'(v), 64'(1));
    check("illegal fun ata", 64'(mbATA), 64'(1));
    wrReg(5'd3, 16'h1);   check("AS clear ata 2", 64'(mbATA), 64'(0));
    rdReg(5'd5, v);       check("bad reg reads 0", 64'(v), 64'(0));
    rdReg(5'd2, v);       check("bad reg ILR", 64'(v), 64'(3));
    goFun(5'o04);
    rdReg(5'd2, v);       check("DRVCLR ER", 64'(v), 64'(0));
    rdReg(5'd0, v);       check("CS1 fun", 64'(v), 64'(16'o210));

    // Bus init in the middle of a READ
    goFun(5'o34);
    xfer(1'b0, 36'h0, g);
    xfer(1'b0, 36'h0, g); check("init word1", 64'(g), 64'(129));
    mbINIT = 1'b1;
    @(negedge clk);
    mbINIT = 1'b0;
    check("init abort", 64'({mbREQO, mbNPRO, mbDRY}), 64'(3'b001));
    b = incbaCnt;
    repeat (6) @(negedge clk);
    check("init no incba", 64'(incbaCnt), 64'(b));
    check("init reqo idle", 64'(mbREQO), 64'(0));
    rdReg(5'd4, v);       check("init DA clear", 64'(v), 64'(0));
    check("init ata", 64'(mbATA), 64'(0));

    $display("%0d/%0d checks passed", passCnt, totCnt);
    $finish;
  end

endmodule
